puf_crp_controller: RTL and testbench

//  Challenge-response sequencer that drives the 8-bit ring-oscillator PUF array and consumes its response.

---
 rtl/puf_crp_controller.sv | 131 +++++++++++++
 tb/tb_puf_crp_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/puf_crp_controller.sv
// puf_crp_controller: challenge/response sequencer for a ring-oscillator PUF with per-bit majority vote; define PUF_UNSTABLE_FLAG_EN to add rsp_unstable
module puf_crp_controller #(
  parameter int CW            = 8,
  parameter int RW            = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_SAMPLES   = 7,
  parameter int SAMPLE_GAP    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_challenge,
  output logic [CW-1:0] puf_challenge,
  output logic          puf_reset,
  input  logic [RW-1:0] puf_response,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [RW-1:0] rsp_response,
  output logic [CW-1:0] rsp_challenge,
`ifdef PUF_UNSTABLE_FLAG_EN
  output logic [RW-1:0] rsp_unstable,
`endif
  output logic          busy
);
  localparam int CNTW = $clog2(NUM_SAMPLES + 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(SAMPLE_GAP > 0 ? SAMPLE_GAP - 1 : 0);
  localparam logic [CNTW-1:0] LAST_SAMPLE = CNTW'(NUM_SAMPLES - 1);
  localparam logic [CNTW-1:0] HALF = CNTW'(NUM_SAMPLES / 2);
  localparam logic [CNTW-1:0] ALL = CNTW'(NUM_SAMPLES);
  typedef enum logic [2:0] {IDLE, PUF_RST, SETTLE, SAMPLE, GAP, VOTE, OUT} state_t;
  state_t                  state_q, state_d;
  logic [15:0]             timer_q, timer_d;
  logic [CNTW-1:0]         sample_q, sample_d;
  logic [RW-1:0][CNTW-1:0] ones_q, ones_d;
  logic [RW-1:0]           sync1_q, sync2_q;
  logic [CW-1:0]           chal_q, chal_d;
  logic [RW-1:0]           resp_q, resp_d;
  logic [CW-1:0]           rchal_q, rchal_d;
`ifdef PUF_UNSTABLE_FLAG_EN
  logic [RW-1:0]           unst_q, unst_d;
  assign rsp_unstable = unst_q;
`endif
  assign req_ready     = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign rsp_valid     = state_q == OUT;
  assign puf_reset     = reset || state_q == PUF_RST;
  assign puf_challenge = chal_q;
  assign rsp_response  = resp_q;
  assign rsp_challenge = rchal_q;
  // free-running two-flop synchronizer for the asynchronous PUF response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= puf_response;
      sync2_q <= sync1_q;
    end
  end
  // sequence state, counters and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      sample_q <= '0;
      ones_q   <= '0;
      chal_q   <= '0;
      resp_q   <= '0;
      rchal_q  <= '0;
`ifdef PUF_UNSTABLE_FLAG_EN
      unst_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      sample_q <= sample_d;
      ones_q   <= ones_d;
      chal_q   <= chal_d;
      resp_q   <= resp_d;
      rchal_q  <= rchal_d;
`ifdef PUF_UNSTABLE_FLAG_EN
      unst_q   <= unst_d;
`endif
    end
  end
  // next state: timed settle/gap waits, per-bit ones counting, majority vote on the final tally
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    sample_d = sample_q;
    ones_d   = ones_q;
    chal_d   = chal_q;
    resp_d   = resp_q;
    rchal_d  = rchal_q;
`ifdef PUF_UNSTABLE_FLAG_EN
    unst_d   = unst_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        chal_d   = req_challenge;
        sample_d = '0;
        ones_d   = '0;
        state_d  = PUF_RST;
      end
      PUF_RST: state_d = SETTLE;
      SETTLE: if (timer_q == SETTLE_LAST) state_d = SAMPLE;
              else timer_d = timer_q + 16'd1;
      SAMPLE: begin
        for (int i = 0; i < RW; i++) ones_d[i] = ones_q[i] + CNTW'(sync2_q[i]);
        sample_d = sample_q + CNTW'(1);
        state_d  = sample_q == LAST_SAMPLE ? VOTE : (SAMPLE_GAP == 0 ? SAMPLE : GAP);
      end
      GAP: if (timer_q == GAP_LAST) state_d = SAMPLE;
           else timer_d = timer_q + 16'd1;
      VOTE: begin
        for (int i = 0; i < RW; i++) begin
          resp_d[i] = ones_q[i] > HALF;
`ifdef PUF_UNSTABLE_FLAG_EN
          unst_d[i] = ones_q[i] != '0 && ones_q[i] != ALL;
`endif
        end
        rchal_d = chal_q;
        state_d = OUT;
      end
      OUT: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_puf_crp_controller.sv
// tb_puf_crp_controller: randomized self-checking bench with a sample-timing vote model
module tb_puf_crp_controller;
  localparam int S = 16, N = 7, G = 4;
  localparam int LAT = 3 + S + N + (N - 1) * G;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic       req_valid, req_ready, puf_reset, rsp_valid, rsp_ready, busy;
  logic [7:0] req_challenge, puf_challenge, puf_response, rsp_response, rsp_challenge;
  logic       c_req_valid, c_req_ready, c_puf_reset, c_rsp_valid, c_rsp_ready, c_busy;
  logic [7:0] c_req_challenge, c_puf_challenge, c_puf_response, c_rsp_response, c_rsp_challenge;
`ifdef PUF_UNSTABLE_FLAG_EN
  logic [7:0] rsp_unstable, c_rsp_unstable;
`endif
  puf_crp_controller dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_challenge(req_challenge), .puf_challenge(puf_challenge), .puf_reset(puf_reset),
    .puf_response(puf_response), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_response(rsp_response), .rsp_challenge(rsp_challenge),
`ifdef PUF_UNSTABLE_FLAG_EN
    .rsp_unstable(rsp_unstable),
`endif
    .busy(busy)
  );
  puf_crp_controller #(.SETTLE_CYCLES(2), .NUM_SAMPLES(1), .SAMPLE_GAP(0)) dut_c (
    .clk(clk), .reset(reset), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_challenge(c_req_challenge), .puf_challenge(c_puf_challenge), .puf_reset(c_puf_reset),
    .puf_response(c_puf_response), .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready),
    .rsp_response(c_rsp_response), .rsp_challenge(c_rsp_challenge),
`ifdef PUF_UNSTABLE_FLAG_EN
    .rsp_unstable(c_rsp_unstable),
`endif
    .busy(c_busy)
  );
  logic [7:0] stim [256];
  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // raw value driven after edge accept+j is seen by sample k when j = S-1 + k*(G+1)
  task automatic txn(input logic [7:0] ch, input int hold);
    logic [7:0] er, eu, keep;
    int j, t, pulses, cnt;
    logic bad;
    for (int b = 0; b < 8; b++) begin
      cnt = 0;
      for (int k = 0; k < N; k++) cnt += int'(stim[S - 1 + k * (G + 1)][b]);
      er[b] = cnt > N / 2;
      eu[b] = cnt != 0 && cnt != N;
    end
    req_challenge = ch;
    req_valid = 1'b1;
    rsp_ready = hold == 0;
    t = 0;
    while (!req_ready && t < 200) begin @(posedge clk); #1; t++; end
    check("accept_wait", 32'(t < 200), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_challenge = 8'($urandom);
    check("puf_challenge", puf_challenge, ch);
    j = 0; pulses = 0;
    puf_response = stim[0];
    while (!rsp_valid && j < 200) begin
      pulses += int'(puf_reset);
      @(posedge clk); #1;
      j++;
      puf_response = stim[j];
    end
    check("latency", j + 1, LAT);
    check("puf_reset_pulses", pulses, 1);
    check("rsp_response", rsp_response, er);
    check("rsp_challenge", rsp_challenge, ch);
`ifdef PUF_UNSTABLE_FLAG_EN
    check("rsp_unstable", rsp_unstable, eu);
`endif
    check("busy_out", {busy, req_ready}, 2'b10);
    keep = rsp_response;
    bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_response !== er || rsp_challenge !== ch || req_ready !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) check("backpressure_hold", bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_after_hs", {req_ready, busy, rsp_valid}, 3'b100);
    check("held_response", rsp_response, keep);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] base, v;
    int j;
    logic seen;
    reset = 1'b1;
    req_valid = 1'b0; req_challenge = '0; puf_response = '0; rsp_ready = 1'b0;
    c_req_valid = 1'b0; c_req_challenge = '0; c_puf_response = '0; c_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {req_ready, rsp_valid, busy, puf_reset}, 4'b1001);
    check("reset_data", {rsp_response, rsp_challenge, puf_challenge}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_puf_reset", puf_reset, 0);
    for (int i = 0; i < 256; i++) stim[i] = 8'hA5;
    txn(8'h3C, 0);
    for (int i = 0; i < 256; i++) stim[i] = 8'h00;
    for (int k = 0; k < 4; k++) stim[S - 1 + k * (G + 1)] = 8'h01;
    txn(8'($urandom), 0);
    for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
    txn(8'h5A, 20);
    req_valid = 1'b1; req_challenge = 8'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_settle_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ctrl", {req_ready, rsp_valid, busy, puf_reset}, 4'b1001);
    check("abort_challenge", puf_challenge, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    check("no_partial_rsp", seen, 0);
    v = 8'($urandom);
    puf_response = v;
    req_valid = 1'b1; req_challenge = 8'h01; rsp_ready = 1'b1;
    j = 0;
    while (!rsp_valid && j < 200) begin @(posedge clk); #1; j++; end
    check("b2b_first_chal", rsp_challenge, 8'h01);
    check("b2b_first_resp", rsp_response, v);
    @(posedge clk); #1;
    check("b2b_idle_gap", req_ready, 1);
    req_challenge = 8'h02;
    @(posedge clk); #1;
    check("b2b_second_accept", {puf_reset, busy, puf_challenge}, {2'b11, 8'h02});
    req_valid = 1'b0;
    j = 0;
    while (!rsp_valid && j < 200) begin @(posedge clk); #1; j++; end
    check("b2b_second_chal", rsp_challenge, 8'h02);
    check("b2b_second_resp", rsp_response, v);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    repeat (8) begin
      base = 8'($urandom);
      for (int i = 0; i < 256; i++) stim[i] = base ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      txn(8'($urandom), int'($urandom_range(0, 3)));
    end
    repeat (4) begin
      for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
      base = 8'($urandom);
      c_req_valid = 1'b1; c_req_challenge = base; c_rsp_ready = 1'b1;
      check("corner_ready", c_req_ready, 1);
      @(posedge clk); #1;
      c_req_valid = 1'b0;
      j = 0;
      c_puf_response = stim[0];
      while (!c_rsp_valid && j < 50) begin @(posedge clk); #1; j++; c_puf_response = stim[j]; end
      check("corner_latency", j + 1, 6);
      check("corner_resp", c_rsp_response, stim[1]);
      check("corner_chal", c_rsp_challenge, base);
`ifdef PUF_UNSTABLE_FLAG_EN
      check("corner_unstable", c_rsp_unstable, 0);
`endif
      @(posedge clk); #1;
      check("corner_idle", {c_req_ready, c_rsp_valid}, 2'b10);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
